// File: rtl/fcore_run_ctrl_pkg.sv
// Shared register map, control-bit positions and channel state type for the
// fCore run controller.
package fcore_run_ctrl_pkg;

   localparam logic [7:0] OFF_CTRL      = 8'h00;
   localparam logic [7:0] OFF_ENABLE    = 8'h04;
   localparam logic [7:0] OFF_PERIOD    = 8'h08;
   localparam logic [7:0] OFF_BUSY      = 8'h0C;
   localparam logic [7:0] OFF_OVR_MASK  = 8'h10;
   localparam logic [7:0] OFF_OVR_COUNT = 8'h14;

   // The window decodes word index addr[4:2] only.
   localparam logic [2:0] IDX_CTRL      = OFF_CTRL[4:2];
   localparam logic [2:0] IDX_ENABLE    = OFF_ENABLE[4:2];
   localparam logic [2:0] IDX_PERIOD    = OFF_PERIOD[4:2];
   localparam logic [2:0] IDX_BUSY      = OFF_BUSY[4:2];
   localparam logic [2:0] IDX_OVR_MASK  = OFF_OVR_MASK[4:2];
   localparam logic [2:0] IDX_OVR_COUNT = OFF_OVR_COUNT[4:2];

   localparam int CTRL_GLOBAL_EN_BIT   = 0;
   localparam int CTRL_SINGLE_SHOT_BIT = 1;

   localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

   typedef enum logic {
      IDLE    = 1'b0,
      RUNNING = 1'b1
   } core_state_t;

endpackage

// File: rtl/fcore_run_channel.sv
// One fCore run/done tracker: issues a run pulse on trigger, holds busy until done.
//
// state   | meaning
// IDLE    | core stopped; trig with enable starts it
// RUNNING | run issued, waiting for done; trig here is an overrun
module fcore_run_channel
   import fcore_run_ctrl_pkg::*;
(
   input  logic clock,
   input  logic reset,
   input  logic trig,
   input  logic enable,
   input  logic done,
   output logic run,
   output logic busy,
   output logic overrun
);

   core_state_t state_q, state_d;
   logic        run_q, run_d;

   always_comb begin
      state_d = state_q;
      run_d   = 1'b0;
      overrun = 1'b0;
      case (state_q)
         IDLE: begin
            if (trig && enable) begin
               state_d = RUNNING;
               run_d   = 1'b1;
            end
         end
         RUNNING: begin
            // done beats a coincident trig, so the core restarts cleanly
            if (done) begin
               if (trig && enable) begin
                  run_d = 1'b1;
               end else begin
                  state_d = IDLE;
               end
            end else if (trig) begin
               overrun = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         run_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         run_q   <= run_d;
      end
   end

   assign run  = run_q;
   assign busy = (state_q == RUNNING);

endmodule

// File: rtl/fcore_run_controller.sv
// Periodic run-strobe generator for an fCore array: AXI-lite register window,
// period timer, per-core channels and a saturating overrun counter.
module fcore_run_controller
   import fcore_run_ctrl_pkg::*;
#(
   parameter int unsigned N_CORES       = 4,
   parameter int unsigned COUNTER_WIDTH = 32,
   parameter int unsigned OVR_CNT_WIDTH = 16,
   parameter logic [31:0] BASE_ADDRESS  = 32'h0
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic [N_CORES-1:0]   done,
   output logic [N_CORES-1:0]   run,
   output logic [N_CORES-1:0]   busy,
   output logic                 tick,
   input  logic [31:0]          axi_in_awaddr,
   input  logic                 axi_in_awvalid,
   output logic                 axi_in_awready,
   input  logic [31:0]          axi_in_wdata,
   input  logic                 axi_in_wvalid,
   output logic                 axi_in_wready,
   output logic [1:0]           axi_in_bresp,
   output logic                 axi_in_bvalid,
   input  logic                 axi_in_bready,
   input  logic [31:0]          axi_in_araddr,
   input  logic                 axi_in_arvalid,
   output logic                 axi_in_arready,
   output logic [31:0]          axi_in_rdata,
   output logic [1:0]           axi_in_rresp,
   output logic                 axi_in_rvalid,
   input  logic                 axi_in_rready
);

   logic                     gen_q, gen_d;
   logic [N_CORES-1:0]       enable_q, enable_d;
   logic [COUNTER_WIDTH-1:0] period_q, period_d;
   logic [N_CORES-1:0]       ovr_mask_q, ovr_mask_d;
   logic [OVR_CNT_WIDTH-1:0] ovr_cnt_q, ovr_cnt_d;
   logic [COUNTER_WIDTH-1:0] cnt_q, cnt_d;
   logic                     tick_q, tick_d;
   logic                     awready_q, awready_d;
   logic                     bvalid_q, bvalid_d;
   logic                     arready_q, arready_d;
   logic                     rvalid_q, rvalid_d;
   logic [31:0]              rdata_q, rdata_d;

   logic [31:0]        wr_off, rd_off;
   logic [2:0]         wr_idx, rd_idx;
   logic               wr_fire, rd_fire;
   logic               ctrl_wr, enable_wr, period_wr, mask_wr, count_wr;
   logic               single_shot, timer_restart, timer_on, at_wrap, trig;
   logic [N_CORES-1:0] ovr_vec;
   logic [31:0]        rd_mux;
   logic               unused_bits;

   assign wr_off  = axi_in_awaddr - BASE_ADDRESS;
   assign rd_off  = axi_in_araddr - BASE_ADDRESS;
   assign wr_idx  = wr_off[4:2];
   assign rd_idx  = rd_off[4:2];
   assign wr_fire = awready_q && axi_in_awvalid && axi_in_wvalid;
   assign rd_fire = arready_q && axi_in_arvalid;

   assign ctrl_wr   = wr_fire && (wr_idx == IDX_CTRL);
   assign enable_wr = wr_fire && (wr_idx == IDX_ENABLE);
   assign period_wr = wr_fire && (wr_idx == IDX_PERIOD);
   assign mask_wr   = wr_fire && (wr_idx == IDX_OVR_MASK);
   assign count_wr  = wr_fire && (wr_idx == IDX_OVR_COUNT);

   assign single_shot   = ctrl_wr && axi_in_wdata[CTRL_SINGLE_SHOT_BIT];
   assign timer_restart = period_wr || (ctrl_wr && !axi_in_wdata[CTRL_GLOBAL_EN_BIT]);
   assign timer_on      = gen_q && (period_q != '0);
   assign at_wrap       = (cnt_q == (period_q - COUNTER_WIDTH'(1)));
   assign trig          = tick_q || single_shot;

   always_comb begin
      awready_d = axi_in_awvalid && axi_in_wvalid && !awready_q && !bvalid_q;
      bvalid_d  = bvalid_q;
      if (wr_fire) begin
         bvalid_d = 1'b1;
      end else if (bvalid_q && axi_in_bready) begin
         bvalid_d = 1'b0;
      end

      arready_d = axi_in_arvalid && !arready_q && !rvalid_q;
      rvalid_d  = rvalid_q;
      rdata_d   = rdata_q;
      if (rd_fire) begin
         rvalid_d = 1'b1;
         rdata_d  = rd_mux;
      end else if (rvalid_q && axi_in_rready) begin
         rvalid_d = 1'b0;
      end

      gen_d    = ctrl_wr   ? axi_in_wdata[CTRL_GLOBAL_EN_BIT] : gen_q;
      enable_d = enable_wr ? axi_in_wdata[N_CORES-1:0]        : enable_q;
      period_d = period_wr ? axi_in_wdata[COUNTER_WIDTH-1:0]  : period_q;

      // Software writes restart the period and swallow the tick due this cycle
      cnt_d  = '0;
      tick_d = 1'b0;
      if (timer_on && !timer_restart) begin
         tick_d = at_wrap;
         cnt_d  = at_wrap ? '0 : cnt_q + COUNTER_WIDTH'(1);
      end

      ovr_mask_d = ovr_mask_q;
      if (mask_wr) begin
         ovr_mask_d = ovr_mask_d & ~axi_in_wdata[N_CORES-1:0];
      end
      ovr_mask_d = ovr_mask_d | ovr_vec;

      ovr_cnt_d = ovr_cnt_q;
      if (count_wr) begin
         ovr_cnt_d = '0;
      end else if ((|ovr_vec) && (ovr_cnt_q != '1)) begin
         ovr_cnt_d = ovr_cnt_q + OVR_CNT_WIDTH'(1);
      end
   end

   always_comb begin
      rd_mux = 32'h0;
      case (rd_idx)
         IDX_CTRL:      rd_mux = 32'(gen_q);
         IDX_ENABLE:    rd_mux = 32'(enable_q);
         IDX_PERIOD:    rd_mux = 32'(period_q);
         IDX_BUSY:      rd_mux = 32'(busy);
         IDX_OVR_MASK:  rd_mux = 32'(ovr_mask_q);
         IDX_OVR_COUNT: rd_mux = 32'(ovr_cnt_q);
         default:       rd_mux = 32'h0;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         gen_q      <= 1'b0;
         enable_q   <= '0;
         period_q   <= '0;
         ovr_mask_q <= '0;
         ovr_cnt_q  <= '0;
         cnt_q      <= '0;
         tick_q     <= 1'b0;
         awready_q  <= 1'b0;
         bvalid_q   <= 1'b0;
         arready_q  <= 1'b0;
         rvalid_q   <= 1'b0;
         rdata_q    <= '0;
      end else begin
         gen_q      <= gen_d;
         enable_q   <= enable_d;
         period_q   <= period_d;
         ovr_mask_q <= ovr_mask_d;
         ovr_cnt_q  <= ovr_cnt_d;
         cnt_q      <= cnt_d;
         tick_q     <= tick_d;
         awready_q  <= awready_d;
         bvalid_q   <= bvalid_d;
         arready_q  <= arready_d;
         rvalid_q   <= rvalid_d;
         rdata_q    <= rdata_d;
      end
   end

   for (genvar i = 0; i < int'(N_CORES); i++) begin : g_core
      fcore_run_channel u_channel (
         .clock   (clock),
         .reset   (reset),
         .trig    (trig),
         .enable  (enable_q[i]),
         .done    (done[i]),
         .run     (run[i]),
         .busy    (busy[i]),
         .overrun (ovr_vec[i])
      );
   end

   assign tick           = tick_q;
   assign axi_in_awready = awready_q;
   assign axi_in_wready  = awready_q;
   assign axi_in_bvalid  = bvalid_q;
   assign axi_in_bresp   = AXI_RESP_OKAY;
   assign axi_in_arready = arready_q;
   assign axi_in_rvalid  = rvalid_q;
   assign axi_in_rdata   = rdata_q;
   assign axi_in_rresp   = AXI_RESP_OKAY;

   assign unused_bits = ^{wr_off, rd_off, axi_in_wdata};

endmodule

// File: tb/tb_fcore_run_controller.sv
// Directed bench for fcore_run_controller: register table plus timed run/tick sequences.
module tb_fcore_run_controller;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic [3:0]  done, run, busy;
   logic        tick;
   logic [31:0] awaddr = '0, wdata = '0, araddr = '0, rdata;
   logic        awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0, arvalid = 1'b0, rready = 1'b0;
   logic        awready, wready, bvalid, arready, rvalid;
   logic [1:0]  bresp, rresp;

   logic [3:0]  auto_done = '0, man_done = '0, auto_en = '0;
   int          pend [4];
   int          cyc = 0;
   int          checks = 0;
   int          errors = 0;
   logic [3:0]  run_log [0:4095];
   logic        tick_log [0:4095];

   assign done = auto_done | man_done;

   fcore_run_controller dut (
      .clock(clock), .reset(reset), .done(done), .run(run), .busy(busy), .tick(tick),
      .axi_in_awaddr(awaddr), .axi_in_awvalid(awvalid), .axi_in_awready(awready),
      .axi_in_wdata(wdata), .axi_in_wvalid(wvalid), .axi_in_wready(wready),
      .axi_in_bresp(bresp), .axi_in_bvalid(bvalid), .axi_in_bready(bready),
      .axi_in_araddr(araddr), .axi_in_arvalid(arvalid), .axi_in_arready(arready),
      .axi_in_rdata(rdata), .axi_in_rresp(rresp), .axi_in_rvalid(rvalid),
      .axi_in_rready(rready)
   );

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   // Log outputs mid-cycle; a run seen in cycle c gets done back in cycle c+3.
   always @(negedge clock) begin
      if (cyc < 4096) begin
         run_log[cyc]  = run;
         tick_log[cyc] = tick;
      end
      for (int i = 0; i < 4; i++) begin
         auto_done[i] = 1'b0;
         if (reset) begin
            pend[i] = 0;
         end else begin
            if (pend[i] != 0) begin
               pend[i] = pend[i] - 1;
               if (pend[i] == 0) auto_done[i] = 1'b1;
            end
            if (run[i] && auto_en[i]) pend[i] = 3;
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic axi_write(input logic [31:0] a, input logic [31:0] d, output int hs);
      int n;
      hs = -1;
      @(negedge clock);
      awaddr = a; wdata = d; awvalid = 1'b1; wvalid = 1'b1;
      n = 0;
      do begin @(negedge clock); n++; end while (!(awready && wready) && n < 16);
      if (!(awready && wready)) begin
         checks++; errors++;
         $display("FAIL wr_timeout addr 0x%0h: got no awready expected awready within 16 cycles", a);
      end
      hs = cyc;
      @(negedge clock);
      awvalid = 1'b0; wvalid = 1'b0;
      chk("wr_awready_pulse", 32'(awready), 32'(1'b0));
      chk("wr_bvalid", 32'(bvalid), 32'(1'b1));
      chk("wr_bresp", 32'(bresp), 32'(2'b00));
      bready = 1'b1;
      @(negedge clock);
      bready = 1'b0;
   endtask

   task automatic axi_read(input logic [31:0] a, output logic [31:0] d);
      int n;
      @(negedge clock);
      araddr = a; arvalid = 1'b1;
      n = 0;
      do begin @(negedge clock); n++; end while (!arready && n < 16);
      if (!arready) begin
         checks++; errors++;
         $display("FAIL rd_timeout addr 0x%0h: got no arready expected arready within 16 cycles", a);
      end
      @(negedge clock);
      arvalid = 1'b0;
      chk("rd_rvalid", 32'(rvalid), 32'(1'b1));
      chk("rd_rresp", 32'(rresp), 32'(2'b00));
      d = rdata;
      rready = 1'b1;
      @(negedge clock);
      rready = 1'b0;
   endtask

   task automatic rd_chk(input string name, input logic [31:0] a, input logic [31:0] exp);
      logic [31:0] v;
      axi_read(a, v);
      chk(name, v, exp);
   endtask

   task automatic wait_until(input int c);
      while (cyc < c) @(negedge clock);
   endtask

   // Period-10 schedule from a CTRL=1 handshake in cycle h: tick at h+11+10j, run one cycle later.
   task automatic check_periodic(input string tag, input int h, input int last,
                                 input logic [3:0] first, input logic [3:0] later);
      for (int t = h + 1; t <= last; t++) begin
         int k;
         logic et;
         logic [3:0] er;
         k  = t - h;
         et = (k >= 11) && ((k - 11) % 10 == 0);
         er = 4'h0;
         if (k >= 12 && (k - 12) % 10 == 0) er = (k == 12) ? first : later;
         chk($sformatf("%s_tick@%0d", tag, k), 32'(tick_log[t]), 32'(et));
         chk($sformatf("%s_run@%0d", tag, k), 32'(run_log[t]), 32'(er));
      end
   endtask

   typedef struct {
      logic        wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp;
   } reg_vec_t;

   reg_vec_t vecs [17];

   initial begin
      int h, h2, h3, h4, rs;
      logic et;

      vecs[0]  = '{1'b0, 32'h00, 32'h0,        32'h0};
      vecs[1]  = '{1'b0, 32'h04, 32'h0,        32'h0};
      vecs[2]  = '{1'b0, 32'h08, 32'h0,        32'h0};
      vecs[3]  = '{1'b0, 32'h0C, 32'h0,        32'h0};
      vecs[4]  = '{1'b0, 32'h10, 32'h0,        32'h0};
      vecs[5]  = '{1'b0, 32'h14, 32'h0,        32'h0};
      vecs[6]  = '{1'b0, 32'h18, 32'h0,        32'h0};
      vecs[7]  = '{1'b1, 32'h1C, 32'hFFFFFFFF, 32'h0};
      vecs[8]  = '{1'b1, 32'h04, 32'h1F,       32'hF};
      vecs[9]  = '{1'b1, 32'h08, 32'hABCD,     32'hABCD};
      vecs[10] = '{1'b1, 32'h0C, 32'hF,        32'h0};
      vecs[11] = '{1'b1, 32'h10, 32'hF,        32'h0};
      vecs[12] = '{1'b1, 32'h24, 32'h5,        32'h5};
      vecs[13] = '{1'b1, 32'h04, 32'h0,        32'h0};
      vecs[14] = '{1'b1, 32'h00, 32'h3,        32'h1};
      vecs[15] = '{1'b1, 32'h00, 32'h0,        32'h0};
      vecs[16] = '{1'b1, 32'h08, 32'h0,        32'h0};

      // Reset values
      repeat (3) @(negedge clock);
      chk("rst_run", 32'(run), 32'h0);
      chk("rst_busy", 32'(busy), 32'h0);
      chk("rst_tick", 32'(tick), 32'h0);
      chk("rst_axi_ready", 32'({awready, wready, arready}), 32'h0);
      chk("rst_axi_valid", 32'({bvalid, rvalid}), 32'h0);
      reset = 1'b0;
      repeat (2) @(negedge clock);

      // Register table
      for (int i = 0; i < 17; i++) begin
         if (vecs[i].wr) axi_write(vecs[i].addr, vecs[i].wdata, h);
         rd_chk($sformatf("vec%0d", i), vecs[i].addr, vecs[i].exp);
      end

      // Basic periodic run, done after 3 cycles
      auto_en = 4'hF;
      axi_write(32'h04, 32'hF, h);
      axi_write(32'h08, 32'd10, h);
      axi_write(32'h00, 32'h1, h);
      wait_until(h + 61);
      axi_write(32'h00, 32'h0, h2);
      check_periodic("basic", h, h + 60, 4'hF, 4'hF);
      repeat (4) @(negedge clock);
      rd_chk("basic_mask", 32'h10, 32'h0);
      rd_chk("basic_count", 32'h14, 32'h0);
      rd_chk("basic_busy", 32'h0C, 32'h0);

      // Overrun: core 2 never completes
      auto_en = 4'b1011;
      axi_write(32'h00, 32'h1, h);
      wait_until(h + 33);
      axi_write(32'h00, 32'h0, h2);
      check_periodic("ovr", h, h + 33, 4'hF, 4'hB);
      rd_chk("ovr_mask", 32'h10, 32'h4);
      rd_chk("ovr_count", 32'h14, 32'h2);
      rd_chk("ovr_busy", 32'h0C, 32'h4);
      @(negedge clock); man_done = 4'h4;
      @(negedge clock); man_done = 4'h0;
      axi_write(32'h10, 32'h4, h2);
      rd_chk("w1c_mask", 32'h10, 32'h0);
      axi_write(32'h14, 32'h0, h2);
      rd_chk("clr_count", 32'h14, 32'h0);
      rd_chk("ovr_busy_after", 32'h0C, 32'h0);

      // done[0] in the same cycle as tick
      auto_en = 4'h0;
      axi_write(32'h04, 32'h1, h);
      axi_write(32'h00, 32'h1, h);
      wait_until(h + 21);
      chk("sim_tick", 32'(tick), 32'h1);
      man_done = 4'h1;
      @(negedge clock);
      man_done = 4'h0;
      chk("sim_run", 32'(run), 32'h1);
      chk("sim_busy", 32'(busy), 32'h1);
      axi_write(32'h00, 32'h0, h2);
      chk("sim_first_run", 32'(run_log[h + 12]), 32'h1);
      rd_chk("sim_mask", 32'h10, 32'h0);
      rd_chk("sim_count", 32'h14, 32'h0);
      @(negedge clock); man_done = 4'h1;
      @(negedge clock); man_done = 4'h0;
      repeat (2) @(negedge clock);
      chk("sim_idle", 32'(busy), 32'h0);
      man_done = 4'h1;
      @(negedge clock); man_done = 4'h0;
      repeat (2) @(negedge clock);
      chk("idle_done_busy", 32'(busy), 32'h0);
      chk("idle_done_run", 32'(run), 32'h0);

      // Single shot with global_en=0
      auto_en = 4'hF;
      axi_write(32'h04, 32'h3, h);
      axi_write(32'h00, 32'h2, h);
      wait_until(h + 10);
      for (int t = h - 1; t <= h + 9; t++) begin
         chk($sformatf("ss_run@%0d", t - h), 32'(run_log[t]), (t == h + 1) ? 32'h3 : 32'h0);
         chk($sformatf("ss_tick@%0d", t - h), 32'(tick_log[t]), 32'h0);
      end
      rd_chk("ss_ctrl", 32'h00, 32'h0);
      rd_chk("ss_busy", 32'h0C, 32'h0);

      // PERIOD write restarts the timer; PERIOD=1 ticks every cycle
      axi_write(32'h04, 32'h0, h);
      axi_write(32'h08, 32'd10, h);
      axi_write(32'h00, 32'h1, h);
      wait_until(h + 14);
      axi_write(32'h08, 32'd10, h2);
      wait_until(h2 + 14);
      for (int t = h + 1; t <= h2 + 13; t++) begin
         if (t <= h2) et = (t - h >= 11) && ((t - h - 11) % 10 == 0);
         else         et = (t - h2 >= 11) && ((t - h2 - 11) % 10 == 0);
         chk($sformatf("restart_tick@%0d", t - h), 32'(tick_log[t]), 32'(et));
      end
      axi_write(32'h08, 32'd1, h3);
      wait_until(h3 + 9);
      for (int t = h3 + 1; t <= h3 + 8; t++) begin
         chk($sformatf("p1_tick@%0d", t - h3), 32'(tick_log[t]), (t == h3 + 1) ? 32'h0 : 32'h1);
      end
      axi_write(32'h00, 32'h0, h4);
      wait_until(h4 + 5);
      for (int t = h4 + 1; t <= h4 + 4; t++) begin
         chk($sformatf("gen_off_tick@%0d", t - h4), 32'(tick_log[t]), 32'h0);
      end

      // Reset while cores are busy
      auto_en = 4'h0;
      axi_write(32'h08, 32'd10, h);
      axi_write(32'h04, 32'hF, h);
      axi_write(32'h00, 32'h1, h);
      wait_until(h + 14);
      chk("pre_rst_busy", 32'(busy), 32'hF);
      reset = 1'b1;
      rs = cyc;
      #1;
      chk("in_rst_busy", 32'(busy), 32'h0);
      chk("in_rst_run", 32'(run), 32'h0);
      chk("in_rst_tick", 32'(tick), 32'h0);
      repeat (3) @(negedge clock);
      reset = 1'b0;
      @(negedge clock); man_done = 4'hF;
      @(negedge clock); man_done = 4'h0;
      repeat (12) @(negedge clock);
      for (int t = rs; t < cyc; t++) begin
         chk($sformatf("post_rst_run@%0d", t - rs), 32'(run_log[t]), 32'h0);
      end
      chk("post_rst_busy", 32'(busy), 32'h0);
      rd_chk("post_rst_enable", 32'h04, 32'h0);
      rd_chk("post_rst_period", 32'h08, 32'h0);
      rd_chk("post_rst_ctrl", 32'h00, 32'h0);
      rd_chk("post_rst_count", 32'h14, 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
